// File: rtl/pixel_layer_counter.sv
// Purpose: gates frame start to the command window and walks (x, y, layer) tuples, layer innermost.
// Latency: frame_req at N -> first tuple valid at N+2; one tuple per cycle thereafter.
// Backpressure: out_ready low holds every out_* stable; out_valid stays high until the last tuple is taken.
module pixel_layer_counter #(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 240,
    parameter int LAYERS   = 4,
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int LW       = 2
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          frame_req,
    input  logic          cmd_pending,
    output logic          cmd_window,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [LW-1:0] out_layer,
    output logic          out_first_layer,
    output logic          out_last_layer,
    output logic          out_last_pixel,
    output logic          frame_done,
    output logic          frame_overrun,
    output logic [15:0]   frame_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RENDER = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LAYERS - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [LW-1:0] L_ONE  = LW'(1);

    state_t        state_q, state_d;
    logic          req_pending_q, req_pending_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   frame_count_q;
    logic          count_inc;
    logic          start;
    logic          last_pixel;

    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST) && (layer_q == L_LAST);

    // Next-state, counter advance and request latch; a request arriving in the
    // same cycle the latch is consumed re-arms it instead of being dropped.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        layer_d       = layer_q;
        count_inc     = 1'b0;
        start         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_pending_q && !cmd_pending) begin
                    state_d = S_RENDER;
                    start   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    layer_d = '0;
                end
            end
            S_RENDER: begin
                if (out_ready) begin
                    if (last_pixel) begin
                        state_d   = S_DONE;
                        count_inc = 1'b1;
                        x_d       = '0;
                        y_d       = '0;
                        layer_d   = '0;
                    end else if (layer_q == L_LAST) begin
                        layer_d = '0;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + Y_ONE;
                        end else begin
                            x_d = x_q + X_ONE;
                        end
                    end else begin
                        layer_d = layer_q + L_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_pending_d = frame_req || (req_pending_q && !start);
        overrun_d     = frame_req && req_pending_q && !start;
    end

    // State, counters and request latch; reset aborts any frame in flight.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_pending_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            layer_q       <= '0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            x_q           <= x_d;
            y_q           <= y_d;
            layer_q       <= layer_d;
            overrun_q     <= overrun_d;
            if (count_inc) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign cmd_window      = (state_q == S_IDLE);
    assign busy            = (state_q == S_RENDER) || (state_q == S_DONE);
    assign out_valid       = (state_q == S_RENDER);
    assign frame_done      = (state_q == S_DONE);
    assign frame_overrun   = overrun_q;
    assign frame_count     = frame_count_q;
    assign out_x           = x_q;
    assign out_y           = y_q;
    assign out_layer       = layer_q;
    assign out_first_layer = (layer_q == '0);
    assign out_last_layer  = (layer_q == L_LAST);
    assign out_last_pixel  = last_pixel;

endmodule

// File: tb/tb_pixel_layer_counter.sv
// Bench for pixel_layer_counter with a 4x2 frame of 2 layers (16 tuples).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected tuples and stall pattern come from a hand-filled table.
module tb_pixel_layer_counter;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        frame_req;
    logic        cmd_pending;
    logic        cmd_window;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic [1:0]  out_layer;
    logic        out_first_layer;
    logic        out_last_layer;
    logic        out_last_pixel;
    logic        frame_done;
    logic        frame_overrun;
    logic [15:0] frame_count;

    pixel_layer_counter #(
        .H_PIXELS(4), .V_PIXELS(2), .LAYERS(2), .XW(9), .YW(8), .LW(2)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .frame_req(frame_req), .cmd_pending(cmd_pending),
        .cmd_window(cmd_window), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_layer(out_layer),
        .out_first_layer(out_first_layer), .out_last_layer(out_last_layer),
        .out_last_pixel(out_last_pixel), .frame_done(frame_done),
        .frame_overrun(frame_overrun), .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         stall;
        logic [8:0] x;
        logic [7:0] y;
        logic [1:0] l;
        logic       last_pixel;
    } vec_t;

    vec_t tbl [16];
    int   checks   = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   ovr;
    int   bad;

    always @(negedge clk_in) if (frame_done === 1'b1) done_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic setv(input int k, input int st, input int x, input int y, input int l, input int lp);
        tbl[k].stall      = st;
        tbl[k].x          = x[8:0];
        tbl[k].y          = y[7:0];
        tbl[k].l          = l[1:0];
        tbl[k].last_pixel = lp[0];
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_tuple(input int k, input string tag);
        chk({tag, "_valid"},      32'(out_valid),       32'd1);
        chk({tag, "_x"},          32'(out_x),           32'(tbl[k].x));
        chk({tag, "_y"},          32'(out_y),           32'(tbl[k].y));
        chk({tag, "_layer"},      32'(out_layer),       32'(tbl[k].l));
        chk({tag, "_first"},      32'(out_first_layer), 32'(tbl[k].l == 2'd0));
        chk({tag, "_last_layer"}, 32'(out_last_layer),  32'(tbl[k].l == 2'd1));
        chk({tag, "_last_pixel"}, 32'(out_last_pixel),  32'(tbl[k].last_pixel));
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 64 && out_valid !== 1'b1; i++) step();
        chk(nm, 32'(out_valid), 32'd1);
    endtask

    // Entry: out_valid already high with tuple 0 showing. Exit: first IDLE cycle.
    task automatic run_frame(input logic [15:0] req_mask, input bit stalls,
                             input logic [15:0] exp_count, output int n_ovr);
        n_ovr = 0;
        for (int k = 0; k < 16; k++) begin
            if (stalls) begin
                for (int s = 0; s < tbl[k].stall; s++) begin
                    out_ready = 1'b0;
                    chk_tuple(k, "stall_hold");
                    step();
                    if (frame_overrun === 1'b1) n_ovr++;
                end
            end
            out_ready = 1'b1;
            frame_req = req_mask[k];
            chk_tuple(k, "tuple");
            chk("cmd_window_render", 32'(cmd_window), 32'd0);
            step();
            frame_req = 1'b0;
            if (frame_overrun === 1'b1) n_ovr++;
        end
        chk("done_pulse",      32'(frame_done), 32'd1);
        chk("done_valid",      32'(out_valid),  32'd0);
        chk("done_busy",       32'(busy),       32'd1);
        chk("done_cmd_window", 32'(cmd_window), 32'd0);
        step();
        if (frame_overrun === 1'b1) n_ovr++;
        chk("idle_done",       32'(frame_done),  32'd0);
        chk("idle_cmd_window", 32'(cmd_window),  32'd1);
        chk("idle_busy",       32'(busy),        32'd0);
        chk("idle_valid",      32'(out_valid),   32'd0);
        chk("frame_count",     32'(frame_count), 32'(exp_count));
    endtask

    initial begin
        //   k  stall x  y  l  last
        setv(0,  0,   0, 0, 0, 0);
        setv(1,  1,   0, 0, 1, 0);
        setv(2,  0,   1, 0, 0, 0);
        setv(3,  2,   1, 0, 1, 0);
        setv(4,  1,   2, 0, 0, 0);
        setv(5,  0,   2, 0, 1, 0);
        setv(6,  0,   3, 0, 0, 0);
        setv(7,  1,   3, 0, 1, 0);
        setv(8,  3,   0, 1, 0, 0);
        setv(9,  0,   0, 1, 1, 0);
        setv(10, 1,   1, 1, 0, 0);
        setv(11, 0,   1, 1, 1, 0);
        setv(12, 0,   2, 1, 0, 0);
        setv(13, 2,   2, 1, 1, 0);
        setv(14, 1,   3, 1, 0, 0);
        setv(15, 0,   3, 1, 1, 1);

        rst_n       = 1'b0;
        frame_req   = 1'b0;
        cmd_pending = 1'b0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst_cmd_window", 32'(cmd_window),    32'd1);
        chk("rst_busy",       32'(busy),          32'd0);
        chk("rst_valid",      32'(out_valid),     32'd0);
        chk("rst_done",       32'(frame_done),    32'd0);
        chk("rst_overrun",    32'(frame_overrun), 32'd0);
        chk("rst_count",      32'(frame_count),   32'd0);
        chk("rst_x",          32'(out_x),         32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid-frame at tuple 7.
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_valid("abort_start");
        for (int k = 0; k < 7; k++) begin
            chk_tuple(k, "pre_abort");
            step();
        end
        chk_tuple(7, "pre_abort");
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid",      32'(out_valid),  32'd0);
        chk("abort_cmd_window", 32'(cmd_window), 32'd1);
        chk("abort_busy",       32'(busy),       32'd0);
        chk("abort_x",          32'(out_x),      32'd0);
        chk("abort_layer",      32'(out_layer),  32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_no_done",    32'(done_seen),   32'd0);
        chk("abort_count",      32'(frame_count), 32'd0);

        // Basic frame with start-latency checks; restarts at (0,0,0).
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        chk("lat_n1_valid",      32'(out_valid),  32'd0);
        chk("lat_n1_cmd_window", 32'(cmd_window), 32'd1);
        step();
        chk("lat_n2_valid",      32'(out_valid),  32'd1);
        run_frame(16'h0000, 1'b0, 16'd1, ovr);
        chk("basic_overruns", 32'(ovr), 32'd0);

        // cmd_pending holds the frame in IDLE for 10 cycles.
        cmd_pending = 1'b1;
        frame_req   = 1'b1;
        step();
        frame_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (cmd_window !== 1'b1 || out_valid !== 1'b0) bad++;
            step();
        end
        if (cmd_window !== 1'b1 || out_valid !== 1'b0) bad++;
        chk("cmd_pending_hold", 32'(bad), 32'd0);
        cmd_pending = 1'b0;
        step();
        chk("start_after_cmd", 32'(out_valid), 32'd1);
        run_frame(16'h0000, 1'b0, 16'd2, ovr);

        // Stalled frame: tuples must hold while out_ready is low.
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_valid("stall_start");
        run_frame(16'h0000, 1'b1, 16'd3, ovr);

        // Three requests during RENDER: first latched, two dropped.
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_valid("ovr_start");
        run_frame(16'h0224, 1'b0, 16'd4, ovr);
        chk("overrun_pulses", 32'(ovr), 32'd2);
        step();
        chk("back_to_back_start", 32'(out_valid), 32'd1);
        run_frame(16'h0000, 1'b0, 16'd5, ovr);
        chk("b2b_overruns", 32'(ovr), 32'd0);

        // frame_count wraps from 0xFFFF to 0x0000.
        force dut.frame_count_q = 16'hFFFF;
        step();
        release dut.frame_count_q;
        chk("forced_count", 32'(frame_count), 32'h0000FFFF);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_valid("wrap_start");
        run_frame(16'h0000, 1'b0, 16'h0000, ovr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
